// File: rtl/fire9_expand1_writeback.sv
// fire9_expand1_writeback: shadows the fire9 expand1 activation vector and drains it,
// LANES words per beat, into the output feature-map RAM. Optional feature macro: FIRE9_EXPAND1_WB_CHECKSUM_EN.
module fire9_expand1_writeback #(
    parameter int DSP_NO = 368,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 8,
    parameter int LANES  = 4,
    parameter int BEATS  = DSP_NO / LANES,
    parameter int ADDR_W = $clog2(WOUT * WOUT * BEATS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fire9_expand1_sample,
    input  logic [WIDTH-1:0]         ofm [0:DSP_NO-1],
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [LANES*WIDTH-1:0]   ram_din,
    output logic                     busy,
    output logic                     overrun,
    output logic                     ram_feedback,
    output logic [31:0]              checksum
);

    localparam int PIXELS = WOUT * WOUT;
    localparam int PIX_W  = $clog2(PIXELS) + 1;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int IDX_W  = $clog2(DSP_NO);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [WIDTH-1:0]         r_shadow [0:DSP_NO-1];
    logic [BEAT_W-1:0]        r_beat;
    logic [PIX_W-1:0]         r_pixel;
    logic                     r_ram_we;
    logic [ADDR_W-1:0]        r_ram_addr;
    logic [LANES*WIDTH-1:0]   r_ram_din;
    logic                     r_busy;
    logic                     r_overrun;
    logic                     r_feedback;

    logic                     w_final;
    logic                     w_last_pixel;
    logic                     w_accept;
    logic                     w_advance;
    logic [PIX_W-1:0]         w_next_pixel;
    logic [ADDR_W-1:0]        w_pix_base;
    logic [IDX_W-1:0]         w_base;
    logic [LANES*WIDTH-1:0]   w_next_din;

    assign w_final      = (r_state == S_WRITE) && (r_beat == BEAT_W'(BEATS - 1));
    assign w_last_pixel = (r_pixel == PIX_W'(PIXELS - 1));
    // A new sample may only land when the bank is free or is on its last beat.
    assign w_accept     = fire9_expand1_sample &&
                          ((r_state == S_IDLE) || (w_final && !w_last_pixel));
    assign w_advance    = (r_state == S_WRITE) && !w_final;
    assign w_next_pixel = w_final ? (r_pixel + PIX_W'(1)) : r_pixel;
    assign w_pix_base   = ADDR_W'(w_next_pixel) * ADDR_W'(BEATS);

    // Select the lanes for the beat registered at the next edge: fresh ofm on accept, else the shadow bank.
    always_comb begin
        w_base     = '0;
        w_next_din = '0;
        if (w_advance) begin
            w_base = (IDX_W'(r_beat) + IDX_W'(1)) * IDX_W'(LANES);
        end else begin
            w_base = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            if (w_accept) begin
                w_next_din[l*WIDTH +: WIDTH] = ofm[IDX_W'(l)];
            end else begin
                w_next_din[l*WIDTH +: WIDTH] = r_shadow[w_base + IDX_W'(l)];
            end
        end
    end

    // Shadow bank capture; contents are don't-care outside an active drain.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_shadow <= ofm;
        end
    end

    // Drain FSM with all RAM-side outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_pixel    <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_feedback <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_WRITE;
                        r_beat     <= '0;
                        r_ram_we   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ram_addr <= w_pix_base;
                        r_ram_din  <= w_next_din;
                    end else begin
                        r_ram_we   <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_final) begin
                        r_pixel <= w_next_pixel;
                        if (w_last_pixel) begin
                            r_state    <= S_DONE;
                            r_ram_we   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_feedback <= 1'b1;
                        end else if (w_accept) begin
                            r_state    <= S_WRITE;
                            r_beat     <= '0;
                            r_ram_we   <= 1'b1;
                            r_busy     <= 1'b1;
                            r_ram_addr <= w_pix_base;
                            r_ram_din  <= w_next_din;
                        end else begin
                            r_state    <= S_IDLE;
                            r_ram_we   <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end else begin
                        r_beat     <= r_beat + BEAT_W'(1);
                        r_ram_addr <= r_ram_addr + ADDR_W'(1);
                        r_ram_din  <= w_next_din;
                        if (fire9_expand1_sample) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_overrun <= r_overrun;
                        end
                    end
                end
                S_DONE: begin
                    r_ram_we   <= 1'b0;
                    r_busy     <= 1'b0;
                    r_feedback <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ram_we <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_din      = r_ram_din;
    assign busy         = r_busy;
    assign overrun      = r_overrun;
    assign ram_feedback = r_feedback;

`ifdef FIRE9_EXPAND1_WB_CHECKSUM_EN
    logic [31:0] w_beat_sum;
    logic [31:0] r_checksum;

    // Zero-extended sum of the lanes about to be written.
    always_comb begin
        w_beat_sum = 32'd0;
        for (int l = 0; l < LANES; l++) begin
            w_beat_sum = w_beat_sum + 32'(w_next_din[l*WIDTH +: WIDTH]);
        end
    end

    // Accumulate on every edge that registers a write beat; naturally frozen in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= 32'd0;
        end else if (w_accept || w_advance) begin
            r_checksum <= r_checksum + w_beat_sum;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_fire9_expand1_writeback.sv
// Self-checking bench for fire9_expand1_writeback: directed vector table, corner sequences,
// and random sample spacing checked every cycle against a transaction-level model.
module tb_fire9_expand1_writeback;

    localparam int DSP_NO = 368;
    localparam int WIDTH  = 16;
    localparam int WOUT   = 8;
    localparam int LANES  = 4;
    localparam int BEATS  = 92;
    localparam int PIXELS = 64;
    localparam int ADDR_W = 13;
`ifdef FIRE9_EXPAND1_WB_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   sample;
    logic [WIDTH-1:0]       ofm [0:DSP_NO-1];
    logic                   ram_we;
    logic [ADDR_W-1:0]      ram_addr;
    logic [LANES*WIDTH-1:0] ram_din;
    logic                   busy;
    logic                   overrun;
    logic                   ram_feedback;
    logic [31:0]            checksum;

    always #5 clk = ~clk;

    fire9_expand1_writeback dut (
        .clk                  (clk),
        .rst                  (rst),
        .fire9_expand1_sample (sample),
        .ofm                  (ofm),
        .ram_we               (ram_we),
        .ram_addr             (ram_addr),
        .ram_din              (ram_din),
        .busy                 (busy),
        .overrun              (overrun),
        .ram_feedback         (ram_feedback),
        .checksum             (checksum)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Transaction-level model: each accepted sample owns the BEATS cycles after its edge.
    int               m_cnt;
    int               m_last;
    int               m_pix;
    bit               m_ovr;
    bit               m_fresh;
    logic [31:0]      m_sum;
    logic [WIDTH-1:0] m_data [0:DSP_NO-1];

    typedef struct {
        int                     beat;
        logic [ADDR_W-1:0]      addr;
        logic [LANES*WIDTH-1:0] din;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit s, input bit r);
        bit                     exp_we;
        int                     k;
        logic [LANES*WIDTH-1:0] exp_din;
        logic [ADDR_W-1:0]      exp_addr;
        sample = s;
        rst    = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_cnt = 0; m_last = 0; m_pix = 0; m_ovr = 1'b0; m_fresh = 1'b1; m_sum = 32'd0;
        end else if (s) begin
            if (m_cnt < PIXELS && (m_cnt == 0 || cyc >= m_last + BEATS)) begin
                m_last = cyc;
                m_pix  = m_cnt;
                m_cnt++;
                for (int i = 0; i < DSP_NO; i++) m_data[i] = ofm[i];
            end else if (cyc < m_last + BEATS) begin
                m_ovr = 1'b1;
            end
        end
        k        = cyc - m_last;
        exp_we   = (m_cnt > 0) && (k < BEATS);
        exp_din  = '0;
        exp_addr = '0;
        if (exp_we) begin
            m_fresh  = 1'b0;
            exp_addr = ADDR_W'(m_pix * BEATS + k);
            for (int l = 0; l < LANES; l++) begin
                exp_din[l*WIDTH +: WIDTH] = m_data[k*LANES + l];
                m_sum = m_sum + 32'(m_data[k*LANES + l]);
            end
        end
        @(negedge clk);
        chk("ram_we", 64'(ram_we), 64'(exp_we));
        chk("busy", 64'(busy), 64'(exp_we));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("ram_feedback", 64'(ram_feedback), 64'(m_cnt == PIXELS && cyc >= m_last + BEATS));
        chk("checksum", 64'(checksum), CK_EN ? 64'(m_sum) : 64'd0);
        if (exp_we || m_fresh) begin
            chk("ram_addr", 64'(ram_addr), 64'(exp_addr));
            chk("ram_din", 64'(ram_din), 64'(exp_din));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) step(1'b0, 1'b0);
    endtask

    task automatic fill_index();
        for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(i);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'(v);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < DSP_NO; i++) ofm[i] = WIDTH'($urandom);
    endtask

    int e0;

    initial begin
        vt[0] = '{beat: 0,  addr: 13'd0,  din: {16'd3,   16'd2,   16'd1,   16'd0}};
        vt[1] = '{beat: 1,  addr: 13'd1,  din: {16'd7,   16'd6,   16'd5,   16'd4}};
        vt[2] = '{beat: 45, addr: 13'd45, din: {16'd183, 16'd182, 16'd181, 16'd180}};
        vt[3] = '{beat: 91, addr: 13'd91, din: {16'd367, 16'd366, 16'd365, 16'd364}};

        rst = 1'b1;
        sample = 1'b0;
        fill_const(0);
        @(negedge clk);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("reset ram_we", 64'(ram_we), 64'd0);
        chk("reset ram_addr", 64'(ram_addr), 64'd0);
        chk("reset ram_din", 64'(ram_din), 64'd0);
        chk("reset flags", 64'({busy, overrun, ram_feedback}), 64'd0);
        chk("reset checksum", 64'(checksum), 64'd0);
        idle(3);

        // Single indexed sample against the vector table.
        fill_index();
        step(1'b1, 1'b0);
        e0 = cyc;
        for (int j = 0; j < 4; j++) begin
            idle_until(e0 + vt[j].beat);
            chk("table ram_we", 64'(ram_we), 64'd1);
            chk("table ram_addr", 64'(ram_addr), 64'(vt[j].addr));
            chk("table ram_din", 64'(ram_din), 64'(vt[j].din));
        end
        chk("single checksum", 64'(checksum), CK_EN ? 64'd67528 : 64'd0);
        step(1'b0, 1'b0);
        chk("single busy low", 64'(busy), 64'd0);
        chk("single we low", 64'(ram_we), 64'd0);
        idle(5);

        // Overrun: second sample 50 cycles in is dropped, next in-spec one writes pixel 1.
        step(1'b0, 1'b1);
        fill_const(7);
        step(1'b1, 1'b0);
        e0 = cyc;
        idle_until(e0 + 49);
        fill_const(9);
        step(1'b1, 1'b0);
        chk("overrun set", 64'(overrun), 64'd1);
        idle_until(e0 + 112);
        fill_const(11);
        step(1'b1, 1'b0);
        chk("after overrun addr", 64'(ram_addr), 64'd92);
        chk("after overrun din", 64'(ram_din), 64'({4{16'd11}}));
        idle(95);

        // Sample coincident with the final beat: no bubble.
        step(1'b0, 1'b1);
        fill_index();
        step(1'b1, 1'b0);
        e0 = cyc;
        idle_until(e0 + 91);
        chk("coincident final addr", 64'(ram_addr), 64'd91);
        fill_const(5);
        step(1'b1, 1'b0);
        chk("coincident we", 64'(ram_we), 64'd1);
        chk("coincident addr", 64'(ram_addr), 64'd92);
        chk("coincident overrun", 64'(overrun), 64'd0);
        idle(95);

        // Reset at beat 40 of pixel 5, then reset racing a sample.
        step(1'b0, 1'b1);
        for (int p = 0; p < 6; p++) begin
            fill_const(p + 1);
            step(1'b1, 1'b0);
            if (p < 5) idle(99);
        end
        e0 = cyc;
        idle_until(e0 + 40);
        chk("pixel5 beat40 addr", 64'(ram_addr), 64'd500);
        step(1'b0, 1'b1);
        chk("midburst rst outputs", 64'({ram_we, busy, overrun, ram_feedback}), 64'd0);
        chk("midburst rst addr", 64'(ram_addr), 64'd0);
        chk("midburst rst din", 64'(ram_din), 64'd0);
        step(1'b1, 1'b1);
        chk("rst beats sample", 64'(ram_we), 64'd0);
        fill_const(3);
        step(1'b1, 1'b0);
        chk("restart addr", 64'(ram_addr), 64'd0);
        chk("restart we", 64'(ram_we), 64'd1);
        idle(95);

        // Full layer at producer spacing.
        step(1'b0, 1'b1);
        for (int p = 0; p < PIXELS; p++) begin
            fill_const(p);
            step(1'b1, 1'b0);
            if (p < PIXELS - 1) idle(112);
        end
        e0 = cyc;
        idle_until(e0 + 91);
        chk("last addr", 64'(ram_addr), 64'd5887);
        chk("last din", 64'(ram_din), 64'({4{16'd63}}));
        chk("feedback before end", 64'(ram_feedback), 64'd0);
        step(1'b0, 1'b0);
        chk("feedback rise", 64'(ram_feedback), 64'd1);
        chk("done we", 64'(ram_we), 64'd0);
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b0);
            idle(20);
        end
        chk("done overrun", 64'(overrun), 64'd0);
        chk("done feedback held", 64'(ram_feedback), 64'd1);

        // Random spacing and data against the model.
        step(1'b0, 1'b1);
        repeat (25) begin
            fill_rand();
            step(1'b1, 1'b0);
            idle($urandom_range(40, 130));
        end
        idle(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fire9_expand1_writeback.md
# fire9_expand1_writeback

Downstream drain stage for the fire9 expand1 MAC array. It captures the DSP_NO parallel activation words on each `fire9_expand1_sample` pulse into a shadow bank. It then streams them, LANES words per cycle, into the output feature-map RAM at pixel-major addresses. After all WOUT² pixels are written, it raises `ram_feedback` back to the producer.

## Interface
- `DSP_NO`, 368, channels per pixel (one per MAC); must be a multiple of LANES
- `WIDTH`, 16, bits per activation word
- `WOUT`, 8, output map side; pixels per layer = WOUT² = 64
- `LANES`, 4, words per RAM write beat; BEATS = DSP_NO/LANES = 92
- `ADDR_W`, $clog2(WOUT²·BEATS) = 13, RAM word-address width
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `fire9_expand1_sample`  in  1  one-cycle pulse: `ofm` valid this cycle
- `ofm`  in  WIDTH × [0:DSP_NO-1]  unpacked array of activations from the producer
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  ADDR_W  RAM beat address
- `ram_din`  out  LANES·WIDTH  packed write data
- `busy`  out  1  shadow bank is draining
- `overrun`  out  1  sticky: a sample was dropped
- `ram_feedback`  out  1  level: layer fully written; held until `rst`
- `checksum`  out  32  running sum of written words (see Configuration)

## Operation
- States: IDLE, WRITE, DONE. Reset enters IDLE.
- Accepted sample:
  - A sample is accepted in IDLE, or in WRITE on the final beat (beat == BEATS-1).
  - On acceptance: copy all `ofm` into the shadow bank, set beat = 0, enter or stay in WRITE.
- WRITE drives one beat per cycle:
  - `ram_we` = 1 and `ram_addr` = pixel·BEATS + beat.
  - `ram_din[WIDTH·(l+1)-1 : WIDTH·l]` = shadow[beat·LANES + l] for l = 0..LANES-1.
- Final beat:
  - pixel increments.
  - If pixel was WOUT²-1, go to DONE.
  - Otherwise go to WRITE (if a new sample was accepted this cycle) or to IDLE.
- Sample in WRITE on a non-final beat: dropped; `overrun` set and held until `rst`. The pixel counter is not advanced for the dropped sample.
- DONE:
  - `ram_feedback` = 1 and `ram_we` = 0.
  - All further samples are ignored and do not set `overrun`.
- `busy` = 1 exactly when state == WRITE.
- Arithmetic:
  - pixel counter is $clog2(WOUT²)+1 bits; beat counter is $clog2(BEATS) bits.
  - Address product is computed in ADDR_W bits without truncation. Maximum address = WOUT²·BEATS-1 = 5887.

## Timing
- Reset values: `ram_we` 0, `ram_addr` 0, `ram_din` 0, `busy` 0, `overrun` 0, `ram_feedback` 0, `checksum` 0. Shadow-bank contents are don't-care.
- Outputs are registered.
- Sample seen at edge N → first write (beat 0) visible in cycle N+1. Beat k is visible in cycle N+1+k; the last beat is at N+BEATS.
- Back-to-back: a sample coincident with the final beat produces beat 0 of the next pixel in the very next cycle, with no bubble. Minimum sample spacing without overrun is BEATS = 92 cycles; the producer spacing is CHIN+1 = 113.
- `ram_feedback` rises in the cycle after the last beat of pixel 63 is driven.
- `rst` mid-burst: all outputs return to reset values in the cycle after `rst` is sampled. The counters clear, and any partial pixel is abandoned.
- `rst` and a sample in the same cycle: reset wins; the sample is discarded.

## Configuration
- `FIRE9_EXPAND1_WB_CHECKSUM_EN` defined:
  - `checksum` accumulates, modulo 2³², the zero-extended sum of all LANES words of every written beat.
  - It is updated on the edge that drives `ram_we` for that beat.
  - It is cleared by `rst` and frozen in DONE.
- Not defined: no accumulator is built and `checksum` is tied to 0.

## Test plan
- Single sample with `ofm[i]` = i:
  - 92 consecutive writes on addresses 0..91.
  - First `ram_din` = {16'd3, 16'd2, 16'd1, 16'd0}; last = {16'd367, 16'd366, 16'd365, 16'd364}.
  - `busy` is low from cycle 93 after the sample.
- 64 samples spaced 113 cycles, with `ofm[i]` = pixel:
  - Last write is to address 5887 with all lanes = 63.
  - `ram_feedback` rises one cycle after that write; `overrun` stays 0.
- Second sample 50 cycles after the first:
  - `overrun` = 1 from the next cycle and the sample is dropped.
  - The following in-spec sample writes starting at address 92.
- Sample coincident with the final beat of pixel 0: pixel-1 beat 0 (address 92) is written in the next cycle, with no idle cycle.
- `rst` asserted at beat 40 of pixel 5:
  - All outputs are 0 in the next cycle.
  - A new sample then writes starting at address 0.
- With `FIRE9_EXPAND1_WB_CHECKSUM_EN`, one sample with `ofm[i]` = i: `checksum` = 67528 after the last beat. Without the macro it reads 0.
